lane_phase_scheduler: RTL
=========================

// Module: lane_phase_scheduler
// PURPOSE
//  Density-driven phase sequencer for the 4-lane junction. Selects which lane gets green and
//  drives SEL into the 4:1 lane MUX, so the selected lane's sensor/indication path follows the
//  green lane. Green time scales with lane density. A skip counter bounds starvation.
//  Sits between the lane sensor front-end and the light drivers.
// PARAMETERS
//  G_BASE    5  green ticks at density 0
//  G_STEP    3  extra green ticks per density level
//  Y_T       2  yellow ticks
//  AR_T      1  all-red clearance ticks
//  MAX_SKIP  3  selections a requesting lane may lose before forced priority
//  CW        6  phase timer width; must hold G_BASE+3*G_STEP-1
// PORTS
//  CLK      in   1  system clock
//  RST_N    in   1  synchronous reset, active low
//  TICK     in   1  1-cycle timebase pulse (e.g. 1 Hz); all durations counted in TICKs
//  REQ      in   4  lane i has waiting vehicles
//  DENS     in   8  2-bit density per lane, lane i = DENS[2i+1:2i]
//  SEL      out  2  index of current/last green lane, to MUX SEL
//  GREEN    out  4  one-hot or zero
//  YELLOW   out  4  one-hot or zero
//  RED      out  4  ~(GREEN|YELLOW), never all-zero per lane
//  PHASE_END out 1  1-cycle pulse when an ALLRED phase completes
// BEHAVIOUR
//  Reset (RST_N=0 at posedge) has priority over TICK and all other inputs. State=IDLE,
//   SEL=0, GREEN=0, YELLOW=0, RED=4'hF, timer=0, all skip counters=0, PHASE_END=0.
//  States: IDLE, GREEN, YELLOW, ALLRED. All outputs are registered and change only on CLK.
//  Timer: loaded with (duration-1) on phase entry. Decrements on each TICK. Phase exits on
//   the edge sampling a TICK while timer==0. A phase lasts exactly `duration` TICKs.
//  IDLE: if any REQ, pick lane L. Next cycle: GREEN, SEL=L, GREEN[L]=1. Entry does not wait
//   for TICK.
//  GREEN: duration = G_BASE + DENS[L]*G_STEP. DENS is latched at entry. Later DENS/REQ changes
//   do not alter it. On expiry:
//   - if no other lane has REQ, re-arm GREEN on L with freshly sampled DENS.
//   - else go to YELLOW[L] for Y_T ticks.
//  YELLOW: then ALLRED (RED=F) for AR_T ticks. SEL holds L throughout both phases.
//  ALLRED exit: PHASE_END pulses for 1 cycle.
//   - if any REQ: pick next lane and go to GREEN in the same edge.
//   - else go to IDLE.
//  Pick rule (combinational, sampled at pick edge):
//   - candidates = REQ lanes; the current lane is excluded unless it is the only requester.
//   - starved (skip==MAX_SKIP) candidates win over all others.
//   - otherwise highest DENS wins.
//   - ties resolve round-robin starting at SEL+1 mod 4 (wraps 3->0).
//  Skip counters: at each pick, every requesting non-winner increments (saturating at
//   MAX_SKIP). The winner and non-requesting lanes clear to 0.
//  Invariants: at most one lane non-red; GREEN&YELLOW==0; no GREEN->GREEN lane change without
//   passing YELLOW+ALLRED.
//  TICK asserted on the entry edge is not counted toward the new phase.
// STRUCTURE
//  Shared package tlc_pkg holds:
//   - state encoding (IDLE=2'd0, GREEN=1, YELLOW=2, ALLRED=3)
//   - lane count NLANE=4
//   - density width DW=2
//  Sub-module lane_pick: combinational arbiter.
//   - inputs: REQ, DENS, skip vectors, current SEL.
//   - outputs: winner index, valid.
//  Top holds the FSM, timer and skip counters.
// TESTING
//  1 Reset: hold RST_N=0 for 3 CLK with TICK=1 and REQ=F -> RED=F, GREEN=0, SEL=0 every cycle.
//  2 Single lane: REQ=4'b0100, DENS lane2=2 -> GREEN[2] for 11 TICKs, then re-armed green with
//    no yellow.
//  3 Density pick: from ALLRED after lane0, REQ=F, DENS={3,1,3,0}
//    (lane3..0) -> lane1 chosen. Next round after lane1 -> lane3 (tie 1/3, RR from 2).
//  4 Sequence timing: lane0 DENS=0 with another REQ -> 5 TICK green, 2 yellow, 1 allred.
//    PHASE_END pulses exactly one cycle.
//  5 Starvation: lane3 REQ with DENS=0, others DENS=3 and always requesting -> lane3 green no
//    later than its 4th pick.
//  6 Reset mid-YELLOW: RST_N=0 -> next edge IDLE, RED=F, skip counters cleared.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the 4-lane junction phase sequencer.
//   - phase_e : FSM phase encoding (IDLE, GREEN, YELLOW, ALLRED)
//   - NLANE   : number of lanes at the junction
//   - DW      : density field width per lane
//   - LW      : lane index width
//   - lane_onehot / dens_at : small helpers shared by the top and the arbiter
package tlc_pkg;

  localparam int unsigned NLANE = 4;
  localparam int unsigned DW    = 2;
  localparam int unsigned LW    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } phase_e;

  typedef logic [DW-1:0] dens_t;
  typedef logic [LW-1:0] lane_t;

  function automatic logic [NLANE-1:0] lane_onehot(input lane_t l);
    logic [NLANE-1:0] oh;
    oh    = '0;
    oh[l] = 1'b1;
    return oh;
  endfunction

  function automatic dens_t dens_at(input logic [NLANE*DW-1:0] v, input lane_t l);
    return v[l*DW +: DW];
  endfunction

endpackage

// File: rtl/lane_pick.sv
// Combinational lane arbiter.
// Ports:
//   req_i   in  NLANE       requesting lanes
//   dens_i  in  NLANE*DW    packed per-lane density
//   skip_i  in  NLANE*SKW   packed per-lane skip counters
//   sel_i   in  LW          current/last green lane (round-robin origin)
//   excl_i  in  1           exclude sel_i unless it is the only requester
//   win_o   out LW          winning lane
//   valid_o out 1           at least one lane requests
// Order of precedence: starved lanes, then highest density, then round-robin
// starting at sel_i+1.
module lane_pick
  import tlc_pkg::*;
#(
  parameter int unsigned SKW      = 2,
  parameter int unsigned MAX_SKIP = 3
) (
  input  logic [NLANE-1:0]     req_i,
  input  logic [NLANE*DW-1:0]  dens_i,
  input  logic [NLANE*SKW-1:0] skip_i,
  input  lane_t                sel_i,
  input  logic                 excl_i,
  output lane_t                win_o,
  output logic                 valid_o
);

  logic [NLANE-1:0] others;
  logic [NLANE-1:0] cand;
  logic [NLANE-1:0] starved;
  logic [NLANE-1:0] pool;
  logic [NLANE-1:0] top;
  dens_t            maxd;
  lane_t            idx;
  logic             found;

  always_comb begin
    others  = req_i & ~lane_onehot(sel_i);
    cand    = (excl_i && (|others)) ? others : req_i;

    starved = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      starved[i] = cand[i] && (skip_i[i*SKW +: SKW] == SKW'(MAX_SKIP));
    end
    pool = (|starved) ? starved : cand;

    maxd = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (pool[i] && (dens_i[i*DW +: DW] > maxd)) maxd = dens_i[i*DW +: DW];
    end
    top = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      top[i] = pool[i] && (dens_i[i*DW +: DW] == maxd);
    end

    // Scan sel+1, sel+2, ..., sel (index arithmetic wraps in LW bits).
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NLANE; k++) begin
      idx = sel_i + lane_t'(k);
      if (!found && top[idx]) begin
        win_o = idx;
        found = 1'b1;
      end
    end

    valid_o = |req_i;
  end

endmodule

// File: rtl/lane_phase_scheduler.sv
// Density-driven phase sequencer for a 4-lane junction.
// Ports:
//   CLK       in  1   system clock
//   RST_N     in  1   synchronous reset, active low
//   TICK      in  1   one-cycle timebase pulse; all durations count TICKs
//   REQ       in  4   lane i has waiting vehicles
//   DENS      in  8   2-bit density per lane, lane i = DENS[2i+1:2i]
//   SEL       out 2   current/last green lane (lane MUX select)
//   GREEN     out 4   one-hot or zero
//   YELLOW    out 4   one-hot or zero
//   RED       out 4   ~(GREEN|YELLOW)
//   PHASE_END out 1   one-cycle pulse when an ALLRED phase completes
module lane_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned G_BASE   = 5,
  parameter int unsigned G_STEP   = 3,
  parameter int unsigned Y_T      = 2,
  parameter int unsigned AR_T     = 1,
  parameter int unsigned MAX_SKIP = 3,
  parameter int unsigned CW       = 6
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                TICK,
  input  logic [NLANE-1:0]    REQ,
  input  logic [NLANE*DW-1:0] DENS,
  output logic [LW-1:0]       SEL,
  output logic [NLANE-1:0]    GREEN,
  output logic [NLANE-1:0]    YELLOW,
  output logic [NLANE-1:0]    RED,
  output logic                PHASE_END
);

  localparam int unsigned SKW = $clog2(MAX_SKIP + 1);

  phase_e               state_q, state_d;
  lane_t                sel_q, sel_d;
  logic [CW-1:0]        timer_q, timer_d;
  logic [NLANE-1:0]     green_q, green_d;
  logic [NLANE-1:0]     yellow_q, yellow_d;
  logic [NLANE-1:0]     red_q, red_d;
  logic                 pe_q, pe_d;
  logic [NLANE*SKW-1:0] skip_q, skip_d;

  lane_t                win;
  logic                 pick_valid;
  logic                 do_pick;
  logic                 expired;

  function automatic logic [CW-1:0] green_load(input dens_t d);
    return CW'(G_BASE + G_STEP * 32'(d) - 1);
  endfunction

  // IDLE has no lane holding the junction, so nothing is excluded there.
  lane_pick #(
    .SKW      (SKW),
    .MAX_SKIP (MAX_SKIP)
  ) u_pick (
    .req_i   (REQ),
    .dens_i  (DENS),
    .skip_i  (skip_q),
    .sel_i   (sel_q),
    .excl_i  (state_q != ST_IDLE),
    .win_o   (win),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    timer_d  = timer_q;
    green_d  = green_q;
    yellow_d = yellow_q;
    skip_d   = skip_q;
    pe_d     = 1'b0;
    do_pick  = 1'b0;
    expired  = TICK && (timer_q == '0);

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) do_pick = 1'b1;
      end
      ST_GREEN: begin
        if (expired) begin
          if (|(REQ & ~lane_onehot(sel_q))) begin
            state_d  = ST_YELLOW;
            green_d  = '0;
            yellow_d = lane_onehot(sel_q);
            timer_d  = CW'(Y_T - 1);
          end else begin
            // Uncontested: keep the lane green with a freshly sampled density.
            timer_d = green_load(dens_at(DENS, sel_q));
          end
        end else if (TICK) begin
          timer_d = timer_q - CW'(1);
        end
      end
      ST_YELLOW: begin
        if (expired) begin
          state_d  = ST_ALLRED;
          yellow_d = '0;
          timer_d  = CW'(AR_T - 1);
        end else if (TICK) begin
          timer_d = timer_q - CW'(1);
        end
      end
      ST_ALLRED: begin
        if (expired) begin
          pe_d = 1'b1;
          if (pick_valid) do_pick = 1'b1;
          else            state_d = ST_IDLE;
        end else if (TICK) begin
          timer_d = timer_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_pick) begin
      state_d  = ST_GREEN;
      sel_d    = win;
      green_d  = lane_onehot(win);
      yellow_d = '0;
      timer_d  = green_load(dens_at(DENS, win));
      for (int unsigned i = 0; i < NLANE; i++) begin
        if (REQ[i] && (lane_t'(i) != win)) begin
          if (skip_q[i*SKW +: SKW] != SKW'(MAX_SKIP))
            skip_d[i*SKW +: SKW] = skip_q[i*SKW +: SKW] + SKW'(1);
        end else begin
          skip_d[i*SKW +: SKW] = '0;
        end
      end
    end

    red_d = ~(green_d | yellow_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      timer_q  <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
      pe_q     <= 1'b0;
      skip_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      pe_q     <= pe_d;
      skip_q   <= skip_d;
    end
  end

  assign SEL       = sel_q;
  assign GREEN     = green_q;
  assign YELLOW    = yellow_q;
  assign RED       = red_q;
  assign PHASE_END = pe_q;

endmodule
